// File: rtl/rf_serial_pkg.sv
// Shared constants and FSM encoding for the serial register-file host.
package rf_serial_pkg;

   localparam int unsigned DATA_W   = 64;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NUM_REGS = 5;
   localparam int unsigned FRAME_W  = DATA_W + ADDR_W;
   localparam int unsigned CNT_W    = 7;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SHIFT_W = 3'd1,
      STORE   = 3'd2,
      SHIFT_A = 3'd3,
      LOAD    = 3'd4,
      READ    = 3'd5,
      RESP    = 3'd6
   } state_t;

endpackage

// File: rtl/rf_serial_host_if.sv
// Command/response handshake bundle between a requester and rf_serial_host.
interface rf_serial_host_if;
   import rf_serial_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/rf_serial_shreg.sv
// Loadable left-shift register: parallel load, serial in at LSB, MSB is the serial tap.
module rf_serial_shreg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         shift,
   input  logic         sin,
   output logic [W-1:0] q
);

   // Parallel load has priority over shifting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (shift) begin
         q <= {q[W-2:0], sin};
      end
   end

endmodule

// File: rtl/rf_serial_host.sv
// Host bridge: turns read/write commands into serial frames for a shift-register
// based register-file device and returns one response per command.
module rf_serial_host
   import rf_serial_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   rf_serial_host_if.slave bus,
   output logic            ser_out,
   output logic            ser_load,
   output logic            ser_store,
   input  logic            ser_in
);

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               ser_out_n, ser_load_n, ser_store_n;
   logic               cmd_ready_q, cmd_ready_n;
   logic               rsp_valid_q, rsp_valid_n;
   logic               rsp_err_q, rsp_err_n;
   logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_n;

   logic               sr_load, sr_shift, sr_sin;
   logic [FRAME_W-1:0] sr_val, sr_q;
   logic               sr_unused;

   // One register serves as frame serializer on writes/address phase and as read capture.
   rf_serial_shreg #(.W(FRAME_W)) u_shreg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (sr_load),
      .load_val (sr_val),
      .shift    (sr_shift),
      .sin      (sr_sin),
      .q        (sr_q)
   );

   // Bits between the serial tap and the captured read word are never observed.
   assign sr_unused = ^sr_q[FRAME_W-2:DATA_W-1];

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;

   // State, bit counter and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         ser_out     <= 1'b0;
         ser_load    <= 1'b0;
         ser_store   <= 1'b0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         ser_out     <= ser_out_n;
         ser_load    <= ser_load_n;
         ser_store   <= ser_store_n;
         cmd_ready_q <= cmd_ready_n;
         rsp_valid_q <= rsp_valid_n;
         rsp_err_q   <= rsp_err_n;
         rsp_rdata_q <= rsp_rdata_n;
      end
   end

   // Next-state and next-output decode. The first serial bit is issued on the accept
   // edge, so the shift register is preloaded with the remainder of the frame.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      ser_out_n   = 1'b0;
      ser_load_n  = 1'b0;
      ser_store_n = 1'b0;
      rsp_valid_n = rsp_valid_q;
      rsp_err_n   = rsp_err_q;
      rsp_rdata_n = rsp_rdata_q;
      sr_load     = 1'b0;
      sr_val      = '0;
      sr_shift    = 1'b0;
      sr_sin      = 1'b0;

      unique case (state)
         IDLE: begin
            if (bus.cmd_valid && cmd_ready_q) begin
               if (bus.cmd_addr >= ADDR_W'(NUM_REGS)) begin
                  state_n     = RESP;
                  rsp_valid_n = 1'b1;
                  rsp_err_n   = 1'b1;
                  rsp_rdata_n = '0;
               end else if (bus.cmd_write) begin
                  state_n   = SHIFT_W;
                  cnt_n     = CNT_W'(FRAME_W - 1);
                  ser_out_n = bus.cmd_wdata[DATA_W-1];
                  sr_load   = 1'b1;
                  sr_val    = {bus.cmd_wdata[DATA_W-2:0], bus.cmd_addr, 1'b0};
               end else begin
                  state_n   = SHIFT_A;
                  cnt_n     = CNT_W'(ADDR_W - 1);
                  ser_out_n = bus.cmd_addr[ADDR_W-1];
                  sr_load   = 1'b1;
                  sr_val    = {bus.cmd_addr[ADDR_W-2:0], {(DATA_W+1){1'b0}}};
               end
            end
         end

         SHIFT_W: begin
            if (cnt != '0) begin
               ser_out_n = sr_q[FRAME_W-1];
               sr_shift  = 1'b1;
               cnt_n     = cnt - CNT_W'(1);
            end else begin
               state_n     = STORE;
               ser_store_n = 1'b1;
            end
         end

         STORE: begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b0;
            rsp_rdata_n = '0;
         end

         SHIFT_A: begin
            if (cnt != '0) begin
               ser_out_n = sr_q[FRAME_W-1];
               sr_shift  = 1'b1;
               cnt_n     = cnt - CNT_W'(1);
            end else begin
               state_n    = LOAD;
               ser_load_n = 1'b1;
            end
         end

         LOAD: begin
            state_n = READ;
            cnt_n   = CNT_W'(DATA_W - 1);
            sr_load = 1'b1;
         end

         READ: begin
            sr_shift = 1'b1;
            sr_sin   = ser_in;
            if (cnt != '0) begin
               cnt_n = cnt - CNT_W'(1);
            end else begin
               state_n     = RESP;
               rsp_valid_n = 1'b1;
               rsp_err_n   = 1'b0;
               rsp_rdata_n = {sr_q[DATA_W-2:0], ser_in};
            end
         end

         RESP: begin
            if (bus.rsp_ready) begin
               state_n     = IDLE;
               rsp_valid_n = 1'b0;
               rsp_err_n   = 1'b0;
               rsp_rdata_n = '0;
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase

      cmd_ready_n = (state_n == IDLE);
   end

endmodule

// File: tb/tb_rf_serial_host.sv
// Directed plus randomized bench for rf_serial_host with a serial register-file device model.
module tb_rf_serial_host;
   import rf_serial_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ser_out, ser_load, ser_store, ser_in;

   int vectors = 0;
   int miscompares = 0;

   rf_serial_host_if bus();

   rf_serial_host dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .ser_out   (ser_out),
      .ser_load  (ser_load),
      .ser_store (ser_store),
      .ser_in    (ser_in)
   );

   always #5 clk = ~clk;

   // Device: {data,addr} shift register plus its own register array.
   logic [FRAME_W-1:0] dev_sr = '0;
   logic [DATA_W-1:0]  dev_rf [32] = '{default: '0};
   assign ser_in = dev_sr[FRAME_W-1];

   always @(posedge clk) begin
      if (ser_load)
         dev_sr[FRAME_W-1:ADDR_W] <= dev_rf[dev_sr[ADDR_W-1:0]];
      else if (ser_store)
         dev_rf[dev_sr[ADDR_W-1:0]] <= dev_sr[FRAME_W-1:ADDR_W];
      else
         dev_sr <= {dev_sr[FRAME_W-2:0], ser_out};
   end

   // Reference model: what the register file should hold after each completed write.
   logic [DATA_W-1:0] exp_rf [32];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Issue one command, observe the serial traffic, then check and retire the response.
   task automatic run_cmd(input bit wr, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wd, input int hold, input bit busy_valid);
      logic [FRAME_W-1:0] frame_obs;
      logic [ADDR_W-1:0]  addr_obs;
      logic [DATA_W-1:0]  rdata_exp;
      bit                 err_exp;
      int cyc, lat_exp, store_cyc, load_cyc, n_store, n_load, n_overlap, n_act;
      frame_obs = '0; addr_obs = '0;
      store_cyc = 0; load_cyc = 0; n_store = 0; n_load = 0; n_overlap = 0; n_act = 0;
      err_exp   = (int'(addr) >= int'(NUM_REGS));
      rdata_exp = (wr || err_exp) ? '0 : exp_rf[addr];
      lat_exp   = err_exp ? 1 : 71;

      @(negedge clk);
      chk("cmd_ready_idle", 128'(bus.cmd_ready), 128'(1));
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'($urandom);
      bus.cmd_addr  = ADDR_W'($urandom);
      bus.cmd_wdata = {$urandom, $urandom};
      cyc = 1;
      while (1) begin
         if (ser_store) begin n_store++; store_cyc = cyc; end
         if (ser_load)  begin n_load++;  load_cyc  = cyc; end
         if (ser_store && ser_load) n_overlap++;
         if (ser_out || ser_load || ser_store) n_act++;
         if (cyc <= int'(FRAME_W)) frame_obs[int'(FRAME_W) - cyc] = ser_out;
         if (cyc <= int'(ADDR_W))  addr_obs[int'(ADDR_W) - cyc]   = ser_out;
         if (bus.rsp_valid || cyc >= 200) break;
         @(negedge clk);
         cyc++;
      end

      chk("rsp_latency", 128'(cyc), 128'(lat_exp));
      chk("strobe_overlap", 128'(n_overlap), 128'(0));
      if (err_exp) begin
         chk("err_no_serial", 128'(n_act), 128'(0));
      end else if (wr) begin
         chk("wr_frame", 128'(frame_obs), 128'({wd, addr}));
         chk("wr_store_cyc", 128'(store_cyc), 128'(70));
         chk("wr_store_cnt", 128'(n_store), 128'(1));
         chk("wr_no_load", 128'(n_load), 128'(0));
      end else begin
         chk("rd_addr_bits", 128'(addr_obs), 128'(addr));
         chk("rd_load_cyc", 128'(load_cyc), 128'(6));
         chk("rd_load_cnt", 128'(n_load), 128'(1));
         chk("rd_no_store", 128'(n_store), 128'(0));
      end
      chk("rsp_err", 128'(bus.rsp_err), 128'(err_exp));
      chk("rsp_rdata", 128'(bus.rsp_rdata), 128'(rdata_exp));

      bus.cmd_valid = busy_valid;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_rsp_valid", 128'(bus.rsp_valid), 128'(1));
         chk("hold_rsp_rdata", 128'(bus.rsp_rdata), 128'(rdata_exp));
         chk("hold_rsp_err", 128'(bus.rsp_err), 128'(err_exp));
         chk("hold_cmd_ready", 128'(bus.cmd_ready), 128'(0));
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk("post_rsp_valid", 128'(bus.rsp_valid), 128'(0));
      chk("post_cmd_ready", 128'(bus.cmd_ready), 128'(1));

      if (wr && !err_exp) begin
         exp_rf[addr] = wd;
         chk("dev_rf_content", 128'(dev_rf[addr]), 128'(wd));
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_ser_out"},   128'(ser_out),       128'(0));
      chk({tag, "_ser_load"},  128'(ser_load),      128'(0));
      chk({tag, "_ser_store"}, 128'(ser_store),     128'(0));
      chk({tag, "_rsp_valid"}, 128'(bus.rsp_valid), 128'(0));
      chk({tag, "_rsp_err"},   128'(bus.rsp_err),   128'(0));
      chk({tag, "_rsp_rdata"}, 128'(bus.rsp_rdata), 128'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) exp_rf[i] = '0;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0;

      // Power-on reset.
      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_cmd_ready", 128'(bus.cmd_ready), 128'(1));
      chk_outputs_zero("post_reset");

      // Write then read back address 3.
      run_cmd(1'b1, 5'd3, 64'hDEAD_BEEF_0123_4567, 0, 1'b0);
      run_cmd(1'b0, 5'd3, 64'h0, 0, 1'b0);

      // Out-of-range addresses, including the first illegal one.
      run_cmd(1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b0);
      run_cmd(1'b0, 5'd5, 64'h0, 0, 1'b0);

      // Response held off for ten cycles with a command pending.
      run_cmd(1'b0, 5'd2, 64'h0, 10, 1'b1);

      // Reset in the middle of a write frame.
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 5'd0;
      bus.cmd_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (29) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_outputs_zero("midframe_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midframe_cmd_ready", 128'(bus.cmd_ready), 128'(1));
      chk("midframe_dev_untouched", 128'(dev_rf[0]), 128'(exp_rf[0]));
      run_cmd(1'b1, 5'd0, 64'h1, 0, 1'b0);
      run_cmd(1'b0, 5'd0, 64'h0, 0, 1'b0);

      // Back-to-back writes to the lowest and highest legal addresses, then read both.
      run_cmd(1'b1, 5'd0, 64'hA5A5_0000_FFFF_1234, 0, 1'b0);
      run_cmd(1'b1, 5'd4, 64'h5A5A_FFFF_0000_8765, 0, 1'b0);
      run_cmd(1'b0, 5'd0, 64'h0, 1, 1'b0);
      run_cmd(1'b0, 5'd4, 64'h0, 1, 1'b0);

      // Randomized command mix against the reference register file.
      for (int i = 0; i < 20; i++) begin
         run_cmd(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)),
                 {$urandom, $urandom}, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
